// File: rtl/softmax_row_packer_if.sv
`default_nettype none
// ============================================================================
// Module      : softmax_row_packer_if
// Description : Stream-in / vector-out bundle of the softmax row packer.
//               Element side: i_en, i_mode, i_data, i_dvalid, i_last,
//               i_flush in; o_ready out.
//               Vector side : o_valid (lane mask), o_vec_valid (strobe),
//               o_length_mode, o_in_flat (lane k at [16k+15:16k]), o_err.
// Revision    : 1.0 - initial release
// ============================================================================
interface softmax_row_packer_if;
  logic          i_en;
  logic [3:0]    i_mode;
  logic [15:0]   i_data;
  logic          i_dvalid;
  logic          i_last;
  logic          i_flush;
  logic          o_ready;
  logic [63:0]   o_valid;
  logic          o_vec_valid;
  logic [3:0]    o_length_mode;
  logic [1023:0] o_in_flat;
  logic          o_err;

  // Producer of the element stream / consumer of the vectors.
  modport master (
    output i_en, i_mode, i_data, i_dvalid, i_last, i_flush,
    input  o_ready, o_valid, o_vec_valid, o_length_mode, o_in_flat, o_err
  );

  // The packer itself.
  modport slave (
    input  i_en, i_mode, i_data, i_dvalid, i_last, i_flush,
    output o_ready, o_valid, o_vec_valid, o_length_mode, o_in_flat, o_err
  );
endinterface
`default_nettype wire

// File: rtl/softmax_row_packer.sv
`default_nettype none
// ============================================================================
// Module      : softmax_row_packer
// Description : Packs a serial stream of Q6.10 scores into 64-lane vectors
//               of 1x64, 2x32 or 4x16 segments and emits each vector as a
//               one-cycle strobe with lane mask and length mode.
// Ports       : i_clk  - clock, rising edge
//               i_rst  - asynchronous active-high reset
//               bus    - softmax_row_packer_if.slave (element stream in,
//                        vector strobe/mask/data/mode/error out)
// Revision    : 1.0 - initial release
// ============================================================================
module softmax_row_packer #(
  parameter int             LANES = 64,
  parameter int             DW    = 16,
  parameter logic [DW-1:0]  PAD   = 16'h8000
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  softmax_row_packer_if.slave   bus
);

  localparam int FLAT = LANES * DW;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  state_t            state, state_nxt;
  logic [3:0]        mode_q;
  logic [1:0]        seg;
  logic [5:0]        idx;
  logic [FLAT-1:0]   vec_data;
  logic [LANES-1:0]  vec_mask;

  logic              accept;
  logic [3:0]        cur_mode;
  logic [1:0]        geo;
  logic [5:0]        lane;
  logic              seg_full;
  logic              last_seg;
  logic              close_seg;
  logic              complete;
  logic [FLAT-1:0]   merged_data;
  logic [LANES-1:0]  merged_mask;

  logic              out_vv;
  logic [LANES-1:0]  out_mask;
  logic [FLAT-1:0]   out_flat;
  logic [3:0]        out_len;
  logic              err;

  // The max stage downstream never stalls, so readiness is just the enable.
  assign bus.o_ready = bus.i_en & ~i_rst;
  assign accept      = bus.i_dvalid & bus.i_en;

  // The first element of a vector arrives in IDLE and must already use the
  // mode it brings with it; later elements use the latched copy.
  assign cur_mode = (state == IDLE) ? bus.i_mode : mode_q;
  assign geo      = (cur_mode < 4'd3) ? cur_mode[1:0] : 2'd0;

  // Lane = seg*S + idx, expressed as bit concatenation since S is a power of 2.
  always_comb begin
    lane     = idx;
    seg_full = (idx == 6'd63);
    last_seg = 1'b1;
    case (geo)
      2'd1: begin
        lane     = {seg[0], idx[4:0]};
        seg_full = (idx[4:0] == 5'd31);
        last_seg = seg[0];
      end
      2'd2: begin
        lane     = {seg, idx[3:0]};
        seg_full = (idx[3:0] == 4'd15);
        last_seg = (seg == 2'd3);
      end
      default: ;
    endcase
  end

  assign close_seg = accept & (bus.i_last | seg_full);
  // Flush only counts with a vector open; an element accepted alongside it
  // is merged first, so it lands in the emitted vector.
  assign complete  = (close_seg & last_seg) |
                     (bus.i_en & bus.i_flush & (state == FILL));

  // Buffer view including this cycle's element.
  always_comb begin
    merged_data = vec_data;
    merged_mask = vec_mask;
    if (accept) begin
      merged_data[lane*DW +: DW] = bus.i_data;
      merged_mask[lane]          = 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  // FSM next state.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept && !complete) state_nxt = FILL;
      FILL: if (complete)            state_nxt = IDLE;
      default:                       state_nxt = IDLE;
    endcase
  end

  // Assembly buffer and segment counters.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      mode_q   <= 4'd0;
      seg      <= 2'd0;
      idx      <= 6'd0;
      vec_data <= {LANES{PAD}};
      vec_mask <= '0;
    end else if (complete) begin
      // Cleared here so an element in the strobe cycle opens a fresh vector.
      seg      <= 2'd0;
      idx      <= 6'd0;
      vec_data <= {LANES{PAD}};
      vec_mask <= '0;
    end else if (accept) begin
      vec_data <= merged_data;
      vec_mask <= merged_mask;
      if (state == IDLE) mode_q <= bus.i_mode;
      if (close_seg) begin
        seg <= seg + 2'd1;
        idx <= 6'd0;
      end else begin
        idx <= idx + 6'd1;
      end
    end
  end

  // Emitted vector: valid only for the strobe cycle, zero otherwise. Not
  // gated by i_en so a strobe scheduled before a stall still lasts one cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      out_vv   <= 1'b0;
      out_mask <= '0;
      out_flat <= '0;
      out_len  <= 4'd0;
      err      <= 1'b0;
    end else begin
      out_vv   <= complete;
      out_mask <= complete ? merged_mask : '0;
      out_flat <= complete ? merged_data : '0;
      out_len  <= complete ? cur_mode : 4'd0;
      if (accept && (state == IDLE) && (bus.i_mode >= 4'd3)) err <= 1'b1;
    end
  end

  assign bus.o_vec_valid   = out_vv;
  assign bus.o_valid       = out_mask;
  assign bus.o_in_flat     = out_flat;
  assign bus.o_length_mode = out_len;
  assign bus.o_err         = err;

endmodule
`default_nettype wire

// File: tb/tb_softmax_row_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_softmax_row_packer
// Description : Self-checking bench for softmax_row_packer. Every cycle is
//               compared against a reference model that rebuilds the vector
//               layout from the list of accepted elements; directed
//               sequences and a vector table add hand-computed checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_softmax_row_packer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  softmax_row_packer_if bus ();
  softmax_row_packer dut (.i_clk(clk), .i_rst(rst), .bus(bus));

  int n_pass  = 0;
  int n_total = 0;

  // ---------------- reference model ----------------
  typedef struct {
    logic [15:0] d;
    logic        last;
  } elem_t;

  elem_t          q[$];          // elements of the open vector
  logic [3:0]     vmode;
  logic           exp_err = 1'b0;
  logic           exp_vv;
  logic [63:0]    exp_mask;
  logic [1023:0]  exp_flat;
  logic [3:0]     exp_len;

  // Lay the open vector out from scratch following the segment rules.
  function automatic void layout(input logic [3:0] m, output logic [1023:0] flat,
                                 output logic [63:0] mask, output int closed);
    int g, s, sg, ix, ln;
    g = (m < 3) ? int'(m) : 0;
    s = 64 >> g;
    flat = {64{16'h8000}};
    mask = '0;
    sg = 0; ix = 0; closed = 0;
    foreach (q[i]) begin
      ln = sg * s + ix;
      flat[ln*16 +: 16] = q[i].d;
      mask[ln] = 1'b1;
      if (q[i].last || ix == s - 1) begin
        sg++; ix = 0; closed++;
      end else begin
        ix++;
      end
    end
  endfunction

  function automatic void model_step(input logic en, dvalid, input logic [15:0] d,
                                     input logic last, flush, input logic [3:0] mode);
    logic          was_fill;
    logic [1023:0] f;
    logic [63:0]   m;
    int            closed, g;
    exp_vv = 1'b0; exp_mask = '0; exp_flat = '0; exp_len = 4'd0;
    if (!en) return;
    was_fill = (q.size() > 0);
    if (dvalid) begin
      if (!was_fill) begin
        vmode = mode;
        if (mode >= 4'd3) exp_err = 1'b1;
      end
      q.push_back('{d: d, last: last});
    end
    if (q.size() > 0) begin
      layout(vmode, f, m, closed);
      g = (vmode < 3) ? int'(vmode) : 0;
      if (closed >= (1 << g) || (flush && was_fill)) begin
        exp_vv = 1'b1; exp_mask = m; exp_flat = f; exp_len = vmode;
        q.delete();
      end
    end
  endfunction

  // ---------------- checking helpers ----------------
  task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, req);
  endtask

  function automatic logic [15:0] lane_of(input int k);
    logic [1023:0] f;
    f = bus.o_in_flat;
    return f[k*16 +: 16];
  endfunction

  // One clock: apply inputs, advance model, compare everything after the edge.
  task automatic drive(input logic en, dvalid, input logic [15:0] d, input logic last,
                       flush, input logic [3:0] mode, input string tag);
    logic rdy, ok;
    int   bad;
    logic [1023:0] fa;
    bus.i_en = en; bus.i_dvalid = dvalid; bus.i_data = d;
    bus.i_last = last; bus.i_flush = flush; bus.i_mode = mode;
    model_step(en, dvalid, d, last, flush, mode);
    #1 rdy = bus.o_ready;
    @(posedge clk);
    #1;
    fa = bus.o_in_flat;
    ok = (bus.o_vec_valid === exp_vv) && (bus.o_valid === exp_mask) &&
         (fa === exp_flat) && (bus.o_length_mode === exp_len) &&
         (bus.o_err === exp_err) && (rdy === en);
    n_total++;
    if (ok) n_pass++;
    else begin
      bad = 0;
      for (int k = 63; k >= 0; k--) if (fa[k*16 +: 16] !== exp_flat[k*16 +: 16]) bad = k;
      $display("FAIL %s: vv=%0b/%0b mask=%h/%h len=%0d/%0d err=%0b/%0b ready=%0b/%0b lane%0d=%h/%h (got/expected)",
               tag, bus.o_vec_valid, exp_vv, bus.o_valid, exp_mask, bus.o_length_mode, exp_len,
               bus.o_err, exp_err, rdy, en, bad, fa[bad*16 +: 16], exp_flat[bad*16 +: 16]);
    end
  endtask

  task automatic idle_inputs();
    bus.i_en = 1'b1; bus.i_dvalid = 1'b0; bus.i_data = '0;
    bus.i_last = 1'b0; bus.i_flush = 1'b0; bus.i_mode = 4'd0;
  endtask

  // Async reset pulse in the middle of a cycle; outputs must clear at once.
  task automatic do_reset(input string tag);
    logic ok;
    idle_inputs();
    #2 rst = 1'b1;
    #1;
    ok = (bus.o_vec_valid === 1'b0) && (bus.o_valid === '0) && (bus.o_in_flat === '0) &&
         (bus.o_length_mode === 4'd0) && (bus.o_err === 1'b0) && (bus.o_ready === 1'b0);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: vv=%0b mask=%h len=%0d err=%0b ready=%0b expected all 0",
                  tag, bus.o_vec_valid, bus.o_valid, bus.o_length_mode, bus.o_err, bus.o_ready);
    q.delete();
    exp_err = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // ---------------- single-element vector table ----------------
  typedef struct {
    logic [3:0]  mode;
    logic [15:0] d;
    logic        strobe_a;   // strobe right after the element (else after flush)
    logic [3:0]  len;
  } tv_t;

  tv_t tv[6];

  task automatic check_single(input int i);
    check_eq($sformatf("tv%0d_mask", i), bus.o_valid, 64'h1);
    check_eq($sformatf("tv%0d_lane0", i), 64'(lane_of(0)), 64'(tv[i].d));
    check_eq($sformatf("tv%0d_lane1_pad", i), 64'(lane_of(1)), 64'h8000);
    check_eq($sformatf("tv%0d_len", i), 64'(bus.o_length_mode), 64'(tv[i].len));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int strobes;
    logic [3:0] rm;

    tv[0] = '{mode: 4'd0, d: 16'h7FFF, strobe_a: 1'b1, len: 4'd0};
    tv[1] = '{mode: 4'd0, d: 16'h8000, strobe_a: 1'b1, len: 4'd0};
    tv[2] = '{mode: 4'd1, d: 16'hFFFF, strobe_a: 1'b0, len: 4'd1};
    tv[3] = '{mode: 4'd2, d: 16'h0001, strobe_a: 1'b0, len: 4'd2};
    tv[4] = '{mode: 4'd1, d: 16'h1234, strobe_a: 1'b0, len: 4'd1};
    tv[5] = '{mode: 4'd2, d: 16'h8001, strobe_a: 1'b0, len: 4'd2};

    // Reset state, with enable high so o_ready proves the reset gating.
    rst = 1'b1;
    idle_inputs();
    @(posedge clk);
    #1;
    check_eq("reset_ready", 64'(bus.o_ready), 64'h0);
    check_eq("reset_vv", 64'(bus.o_vec_valid), 64'h0);
    check_eq("reset_mask", bus.o_valid, 64'h0);
    check_eq("reset_err", 64'(bus.o_err), 64'h0);
    rst = 1'b0;

    // Mode 0 full row.
    for (int k = 0; k < 64; k++) begin
      drive(1, 1, 16'(k*10 + 10), k == 63, 0, 4'd0, "m0_row");
      if (k == 62) check_eq("m0_no_early_strobe", 64'(bus.o_vec_valid), 64'h0);
    end
    check_eq("m0_strobe", 64'(bus.o_vec_valid), 64'h1);
    check_eq("m0_mask", bus.o_valid, '1);
    check_eq("m0_lane63", 64'(lane_of(63)), 64'd640);
    check_eq("m0_lane0", 64'(lane_of(0)), 64'd10);
    drive(1, 0, 0, 0, 0, 4'd0, "m0_after");
    check_eq("m0_strobe_one_cycle", 64'(bus.o_vec_valid), 64'h0);

    // Mode 1: short row A, full row B.
    for (int k = 0; k < 5; k++) drive(1, 1, 16'h0100, k == 4, 0, 4'd1, "m1_rowA");
    for (int k = 0; k < 32; k++) drive(1, 1, 16'h0200, 0, 0, 4'd1, "m1_rowB");
    check_eq("m1_mask", bus.o_valid, 64'hFFFFFFFF0000001F);
    check_eq("m1_lane4", 64'(lane_of(4)), 64'h0100);
    check_eq("m1_lane5_pad", 64'(lane_of(5)), 64'h8000);
    check_eq("m1_lane32", 64'(lane_of(32)), 64'h0200);
    check_eq("m1_len", 64'(bus.o_length_mode), 64'd1);

    // Mode 2: row overflowing into segment 1, then flush.
    for (int k = 0; k < 20; k++) drive(1, 1, 16'(k + 1), 0, 0, 4'd2, "m2_row");
    check_eq("m2_no_strobe", 64'(bus.o_vec_valid), 64'h0);
    drive(1, 0, 0, 0, 1, 4'd2, "m2_flush");
    check_eq("m2_mask", bus.o_valid, 64'h00000000000FFFFF);
    check_eq("m2_len", 64'(bus.o_length_mode), 64'd2);
    check_eq("m2_lane19", 64'(lane_of(19)), 64'd20);

    // Single-element vectors from the table.
    for (int i = 0; i < 6; i++) begin
      drive(1, 1, tv[i].d, 1, 0, tv[i].mode, $sformatf("tv%0d_elem", i));
      check_eq($sformatf("tv%0d_strobeA", i), 64'(bus.o_vec_valid), 64'(tv[i].strobe_a));
      if (tv[i].strobe_a) check_single(i);
      drive(1, 0, 0, 0, 1, tv[i].mode, $sformatf("tv%0d_flush", i));
      check_eq($sformatf("tv%0d_strobeB", i), 64'(bus.o_vec_valid), 64'(!tv[i].strobe_a));
      if (!tv[i].strobe_a) check_single(i);
    end

    // Back-to-back mode-0 vectors, continuous valid.
    strobes = 0;
    for (int k = 0; k < 128; k++) begin
      drive(1, 1, 16'(16'h4000 + k), (k % 64) == 63, 0, 4'd0, "b2b");
      if (bus.o_vec_valid) strobes++;
      if (k == 63 || k == 127) check_eq($sformatf("b2b_strobe_%0d", k), 64'(bus.o_vec_valid), 64'h1);
    end
    check_eq("b2b_count", 64'(strobes), 64'd2);
    check_eq("b2b_second_lane0", 64'(lane_of(0)), 64'h4040);

    // Unsupported mode 5.
    for (int k = 0; k < 64; k++) drive(1, 1, 16'(k), 0, 0, 4'd5, "m5_row");
    check_eq("m5_err", 64'(bus.o_err), 64'h1);
    check_eq("m5_len", 64'(bus.o_length_mode), 64'd5);
    check_eq("m5_mask", bus.o_valid, '1);
    drive(1, 1, 16'h0033, 1, 0, 4'd0, "m5_next");
    check_eq("m5_err_sticky", 64'(bus.o_err), 64'h1);
    do_reset("m5_reset_clears");

    // Stall mid-row, then completion followed by a stalled cycle.
    for (int k = 0; k < 10; k++) drive(1, 1, 16'(100 + k), 0, 0, 4'd0, "stall_pre");
    for (int k = 0; k < 3; k++) begin
      drive(0, 1, 16'hDEAD, 1, 1, 4'd1, "stall_hold");
      check_eq("stall_no_strobe", 64'(bus.o_vec_valid), 64'h0);
    end
    for (int k = 10; k < 64; k++) drive(1, 1, 16'(100 + k), k == 63, 0, 4'd0, "stall_post");
    check_eq("stall_lane10", 64'(lane_of(10)), 64'd110);
    check_eq("stall_lane63", 64'(lane_of(63)), 64'd163);
    drive(0, 1, 16'h1111, 0, 0, 4'd0, "stall_after_strobe");
    check_eq("stall_strobe_one_cycle", 64'(bus.o_vec_valid), 64'h0);

    // Reset mid-fill discards the partial vector.
    for (int k = 0; k < 10; k++) drive(1, 1, 16'(k), 0, 0, 4'd1, "rst_pre");
    do_reset("rst_midfill");
    for (int k = 0; k < 64; k++) drive(1, 1, 16'(500 + k), k == 63, 0, 4'd0, "rst_post");
    check_eq("rst_post_lane0", 64'(lane_of(0)), 64'd500);
    check_eq("rst_post_mask", bus.o_valid, '1);

    // Randomized traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      rm = ($urandom_range(0, 15) < 13) ? 4'($urandom_range(0, 2)) : 4'($urandom_range(3, 15));
      drive($urandom_range(0, 9) != 0, $urandom_range(0, 4) != 0, 16'($urandom),
            $urandom_range(0, 9) == 0, $urandom_range(0, 29) == 0, rm, "random");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
